// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-back L1 data cache.
package l1_dcache_ctrl_pkg;

  localparam int unsigned CACHE_LINE_SIZE = 16;

  typedef enum logic [1:0] {
    DC_IDLE   = 2'd0,
    DC_LOOKUP = 2'd1,
    DC_WB     = 2'd2,
    DC_REFILL = 2'd3
  } dc_state_e;

  typedef struct packed {
    logic        we;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dc_req_t;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_dcache_ctrl_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous
// full-line refill write and byte-merged word write.
module l1_dcache_ctrl_array import l1_dcache_ctrl_pkg::*; #(
  parameter  int unsigned LINE_BYTES = CACHE_LINE_SIZE,
  parameter  int unsigned NUM_LINES  = 64,
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W      = $clog2(NUM_LINES),
  localparam int unsigned TAG_W      = 32 - OFF_W - IDX_W,
  localparam int unsigned LINE_W     = LINE_BYTES * 8,
  localparam int unsigned WSEL_W     = (OFF_W > 2) ? OFF_W - 2 : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_line_we,
  input  logic [LINE_W-1:0] i_line,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_word_we,
  input  logic [WSEL_W-1:0] i_word_sel,
  input  logic [31:0]       i_word,
  input  logic [3:0]        i_word_strb,
  input  logic              i_clean
);

  logic [LINE_W-1:0]    r_data [NUM_LINES];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [31:0]          w_base;
  logic [31:0]          w_old_word;

  assign o_tag      = r_tag[i_idx];
  assign o_valid    = r_valid[i_idx];
  assign o_dirty    = r_dirty[i_idx];
  assign o_line     = r_data[i_idx];
  assign w_base     = 32'(i_word_sel) * 32'd32;
  assign w_old_word = o_line[w_base +: 32];

  // Data and tag payload; deliberately not reset, validity is tracked separately
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_data[i_idx] <= i_line;
      r_tag[i_idx]  <= i_tag;
    end else if (i_word_we) begin
      r_data[i_idx][w_base +: 32] <= merge_word(w_old_word, i_word, i_word_strb);
    end
  end

  // Valid/dirty state; reset wipes every line so no partial refill survives
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= {NUM_LINES{1'b0}};
      r_dirty <= {NUM_LINES{1'b0}};
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end else if (i_clean) begin
      r_dirty[i_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller in front
// of a line-wide memory; request latch and miss FSM live here.
module l1_dcache_ctrl import l1_dcache_ctrl_pkg::*; #(
  parameter  int unsigned LINE_BYTES = CACHE_LINE_SIZE,
  parameter  int unsigned NUM_LINES  = 64,
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W      = $clog2(NUM_LINES),
  localparam int unsigned TAG_W      = 32 - OFF_W - IDX_W,
  localparam int unsigned LINE_W     = LINE_BYTES * 8,
  localparam int unsigned WSEL_W     = (OFF_W > 2) ? OFF_W - 2 : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [3:0]        i_cpu_wstrb,
  output logic              o_cpu_done,
  output logic [31:0]       o_cpu_rdata,
  output logic [31:0]       o_mem_addr,
  output logic              o_mem_strobe,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic [LINE_W-1:0] i_mem_rdata,
  input  logic              i_mem_read_done,
  input  logic              i_mem_write_done
);

  dc_state_e         r_state;
  dc_req_t           r_req;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [WSEL_W-1:0] w_word_sel;
  logic [TAG_W-1:0]  w_tag;
  logic              w_valid;
  logic              w_dirty;
  logic [LINE_W-1:0] w_line;
  logic              w_hit;
  logic [31:0]       w_rd_word;
  logic              w_line_we;
  logic              w_word_we;
  logic              w_clean;
  logic              w_unused_addr_lsbs;

  assign w_idx              = r_req.addr[OFF_W+IDX_W-1:OFF_W];
  assign w_req_tag          = r_req.addr[31:OFF_W+IDX_W];
  assign w_hit              = w_valid && (w_tag == w_req_tag);
  assign w_rd_word          = w_line[32'(w_word_sel) * 32'd32 +: 32];
  assign w_unused_addr_lsbs = ^i_cpu_addr[1:0];

  generate
    if (OFF_W > 2) begin : g_word_sel
      assign w_word_sel = r_req.addr[OFF_W-1:2];
    end else begin : g_single_word
      assign w_word_sel = 1'b0;
    end
  endgenerate

  // Array writes happen only in the cycle the FSM commits them; reset blocks all
  assign w_word_we = !i_rst && (r_state == DC_LOOKUP) && w_hit && r_req.we;
  assign w_clean   = !i_rst && (r_state == DC_WB) && i_mem_write_done;
  assign w_line_we = !i_rst && (r_state == DC_REFILL) && o_mem_read && i_mem_read_done;

  l1_dcache_ctrl_array #(
    .LINE_BYTES (LINE_BYTES),
    .NUM_LINES  (NUM_LINES)
  ) u_array (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_idx       (w_idx),
    .o_tag       (w_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_line      (w_line),
    .i_line_we   (w_line_we),
    .i_line      (i_mem_rdata),
    .i_tag       (w_req_tag),
    .i_word_we   (w_word_we),
    .i_word_sel  (w_word_sel),
    .i_word      (r_req.wdata),
    .i_word_strb (r_req.wstrb),
    .i_clean     (w_clean)
  );

  // Controller FSM with request latch and registered cpu/mem outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= DC_IDLE;
      r_req        <= {$bits(dc_req_t){1'b0}};
      o_cpu_done   <= 1'b0;
      o_cpu_rdata  <= 32'd0;
      o_mem_addr   <= 32'd0;
      o_mem_strobe <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_wdata  <= {LINE_W{1'b0}};
    end else begin
      o_cpu_done <= 1'b0;
      case (r_state)
        DC_IDLE: begin
          // the done cycle swallows a still-held request from the previous op
          if (i_cpu_req && !o_cpu_done) begin
            r_req   <= '{we: i_cpu_we, addr: i_cpu_addr[31:2],
                         wdata: i_cpu_wdata, wstrb: i_cpu_wstrb};
            r_state <= DC_LOOKUP;
          end
        end
        DC_LOOKUP: begin
          if (w_hit) begin
            o_cpu_done <= 1'b1;
            if (!r_req.we) begin
              o_cpu_rdata <= w_rd_word;
            end
            r_state <= DC_IDLE;
          end else if (w_valid && w_dirty) begin
            o_mem_strobe <= 1'b1;
            o_mem_write  <= 1'b1;
            o_mem_addr   <= {w_tag, w_idx, {OFF_W{1'b0}}};
            o_mem_wdata  <= w_line;
            r_state      <= DC_WB;
          end else begin
            o_mem_strobe <= 1'b1;
            o_mem_read   <= 1'b1;
            o_mem_addr   <= {w_req_tag, w_idx, {OFF_W{1'b0}}};
            r_state      <= DC_REFILL;
          end
        end
        DC_WB: begin
          if (i_mem_write_done) begin
            o_mem_strobe <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_addr   <= 32'd0;
            o_mem_wdata  <= {LINE_W{1'b0}};
            r_state      <= DC_REFILL;
          end
        end
        DC_REFILL: begin
          // entered from writeback with strobe low: raise the read one cycle later
          if (!o_mem_read) begin
            o_mem_strobe <= 1'b1;
            o_mem_read   <= 1'b1;
            o_mem_addr   <= {w_req_tag, w_idx, {OFF_W{1'b0}}};
          end else if (i_mem_read_done) begin
            o_mem_strobe <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_addr   <= 32'd0;
            r_state      <= DC_LOOKUP;
          end
        end
        default: begin
          r_state <= DC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: vector table, scoreboard queue and a
// line-wide memory model preloaded with word n = 0x1000_0000 + n.
module tb_l1_dcache_ctrl;

  localparam int LB = 16;
  localparam int LW = LB * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_done;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]    cpu_wstrb;
  logic [31:0]   mem_addr;
  logic          mem_strobe, mem_read, mem_write;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_read_done, mem_write_done;
  logic          mdl_rd_done, mdl_wr_done, inj_rd, inj_wr;

  always #5 clk = ~clk;

  assign mem_read_done  = mdl_rd_done | inj_rd;
  assign mem_write_done = mdl_wr_done | inj_wr;

  l1_dcache_ctrl #(.LINE_BYTES(LB), .NUM_LINES(64)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_wstrb(cpu_wstrb),
    .o_cpu_done(cpu_done), .o_cpu_rdata(cpu_rdata),
    .o_mem_addr(mem_addr), .o_mem_strobe(mem_strobe), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_read_done(mem_read_done), .i_mem_write_done(mem_write_done)
  );

  typedef struct { logic we; logic [31:0] addr; logic [LW-1:0] wdata; } txn_t;
  typedef struct { logic we; logic [31:0] rdata; } exp_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] exp_rdata; int exp_lat; int exp_txn;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  txn_t        txn_q[$];
  exp_t        sbq[$];
  logic [31:0] mdl_mem [int unsigned];
  int          mdl_lat = 3;
  int          mdl_cnt = 0;
  int          both_cnt = 0;
  int          unstable_cnt = 0;
  txn_t        cur;

  function automatic logic [31:0] rd_word(input int unsigned n);
    if (mdl_mem.exists(n)) return mdl_mem[n];
    return 32'h1000_0000 + n;
  endfunction

  // Memory model: logs each transaction, checks it stays stable, answers after mdl_lat cycles
  always @(negedge clk) begin
    mdl_rd_done = 1'b0;
    mdl_wr_done = 1'b0;
    if (mem_read && mem_write) both_cnt++;
    if (!mem_strobe) begin
      mdl_cnt = 0;
    end else begin
      if (mdl_cnt == 0) begin
        cur.we = mem_write; cur.addr = mem_addr; cur.wdata = mem_wdata;
        txn_q.push_back(cur);
      end else if (mem_addr !== cur.addr || mem_write !== cur.we ||
                   (cur.we && mem_wdata !== cur.wdata)) begin
        unstable_cnt++;
      end
      mdl_cnt++;
      if (mdl_cnt == mdl_lat) begin
        if (mem_write) begin
          for (int k = 0; k < LB/4; k++) mdl_mem[mem_addr/4 + k] = mem_wdata[k*32 +: 32];
          mdl_wr_done = 1'b1;
        end else if (mem_read) begin
          for (int k = 0; k < LB/4; k++) mem_rdata[k*32 +: 32] = rd_word(mem_addr/4 + k);
          mdl_rd_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Issues one request; expectation goes to the scoreboard, popped when cpu_done appears
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, output int lat);
    exp_t e;
    bit   seen;
    e.we = we; e.rdata = exp_rd;
    sbq.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = st;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        cpu_we = ~we; cpu_addr = addr ^ 32'h0000_0C04; cpu_wdata = ~wd; cpu_wstrb = ~st;
      end
      if (cpu_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL cpu_done_timeout addr=0x%08h actual=none required=done", addr);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      if (!e.we) chk($sformatf("rdata@%08h", addr), cpu_rdata, e.rdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", cpu_done, 1'b0);
  endtask

  vec_t vecs[8];
  int   lat, n0;
  bit   seen;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h1000_0001, 0, 1};
    vecs[1] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'h1000_0003, 2, 0};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         2, 0};
    vecs[3] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 32'h0,         2, 0};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hDEAD_5678, 2, 0};
    vecs[5] = '{1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'hC, 32'h0,         2, 0};
    vecs[6] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hAABB_0001, 2, 0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1000_0000, 2, 0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cpu_wstrb = 4'h0; inj_rd = 1'b0; inj_wr = 1'b0; mem_rdata = '0;
    mdl_rd_done = 1'b0; mdl_wr_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_done", cpu_done, 1'b0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_strobe", mem_strobe, 1'b0);
    chk("reset_read", mem_read, 1'b0);
    chk("reset_write", mem_write, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      n0 = txn_q.size();
      cpu_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].exp_rdata, lat);
      chk($sformatf("vec%0d_mem_txns", v), txn_q.size() - n0, vecs[v].exp_txn);
      if (vecs[v].exp_lat != 0) chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
    end
    chk("fill_is_read", txn_q[0].we, 1'b0);
    chk("fill_addr", txn_q[0].addr, 32'h0);

    // dirty victim: writeback of line 0 then refill of 0x400
    n0 = txn_q.size();
    cpu_op(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'h1000_0100, lat);
    chk("wb_refill_txns", txn_q.size() - n0, 2);
    if (txn_q.size() - n0 == 2) begin
      chk("wb_is_write", txn_q[n0].we, 1'b1);
      chk("wb_addr", txn_q[n0].addr, 32'h0);
      chk("wb_word2", txn_q[n0].wdata[95:64], 32'hDEAD_5678);
      chk("wb_word1", txn_q[n0].wdata[63:32], 32'hAABB_0001);
      chk("refill_is_read", txn_q[n0+1].we, 1'b0);
      chk("refill_addr", txn_q[n0+1].addr, 32'h400);
    end

    // reset in the middle of a clean-miss refill
    mdl_lat = 10;
    n0 = txn_q.size();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0800;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_strobe && mem_read) seen = 1'b1;
    end
    chk("rst_refill_started", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobe", mem_strobe, 1'b0);
    chk("rst_mid_read", mem_read, 1'b0);
    chk("rst_mid_done", cpu_done, 1'b0);
    rst = 1'b0; cpu_req = 1'b0;
    mdl_lat = 3;
    repeat (3) @(negedge clk);
    chk("rst_no_late_done", cpu_done, 1'b0);
    n0 = txn_q.size();
    cpu_op(1'b0, 32'h0000_0800, 32'h0, 4'h0, 32'h1000_0200, lat);
    chk("after_rst_refill_txns", txn_q.size() - n0, 1);
    if (txn_q.size() > n0) chk("after_rst_refill_addr", txn_q[n0].addr, 32'h800);
    n0 = txn_q.size();
    cpu_op(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'hDEAD_5678, lat);
    chk("writeback_landed_txns", txn_q.size() - n0, 1);

    // spurious completions while idle
    @(negedge clk); inj_rd = 1'b1;
    @(negedge clk); inj_rd = 1'b0; inj_wr = 1'b1;
    @(negedge clk); inj_wr = 1'b0;
    chk("spurious_done", cpu_done, 1'b0);
    chk("spurious_strobe", mem_strobe, 1'b0);
    @(negedge clk);
    chk("spurious_done_later", cpu_done, 1'b0);
    n0 = txn_q.size();
    cpu_op(1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h1000_0003, lat);
    chk("post_spurious_latency", lat, 2);
    chk("post_spurious_txns", txn_q.size() - n0, 0);

    chk("read_write_exclusive", both_cnt, 0);
    chk("mem_req_stable", unstable_cnt, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
